conv_engine: RTL and testbench

Parametrised successor to the fixed 3x3, 8-bit convolution datapath. It loads one K x K data window and one K x K weight window, one kernel row per handshake, then computes the dot product in a two-stage multiply/sum pipeline. It adds a backpressure handshake, a signed/unsigned mode, weight-stationary reuse and saturating output. It sits between the row streamer and the output writeback in the convolution path.

---
 rtl/conv_pkg.sv | 45 ++++
 rtl/conv_win_buf.sv | 85 ++++++++
 rtl/conv_engine.sv | 140 ++++++++++++++
 tb/tb_conv_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution engine.
//   conv_state_t : engine FSM states (load rows, register products, sum/clamp)
//   clamp_t      : clamp result, clamped value plus an overflow flag
//   conv_clamp   : saturate a signed 64-bit value to out_w bits, signed or unsigned
package conv_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_MULT,
        S_SUM
    } conv_state_t;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] val;
    } clamp_t;

    // Limits are computed at 64 bits so one function serves any out_w < 64.
    function automatic clamp_t conv_clamp(input logic signed [63:0] val,
                                          input int unsigned        out_w,
                                          input logic               is_signed);
        clamp_t             res;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (is_signed) begin
            hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (out_w - 1));
        end else begin
            hi = (64'sd1 <<< out_w) - 64'sd1;
            lo = 64'sd0;
        end
        if (val > hi) begin
            res.val = hi;
            res.ovf = 1'b1;
        end else if (val < lo) begin
            res.val = lo;
            res.ovf = 1'b1;
        end else begin
            res.val = val;
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_win_buf.sv
// conv_win_buf: K x K data and weight window registers filled one row per accept.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   accept            a row is taken this cycle (send && ready)
//   data, wt          packed rows, element c at [c*DATA_W +: DATA_W]
//   keep_wt           sampled on row 0: keep stored weights for this window
//   is_signed         sampled on row 0: signed operands for this window
//   win_d, win_w      flat windows, element (r,c) at [(r*K+c)*DATA_W +: DATA_W]
//   win_signed        latched signed mode of the current window
//   window_full       pulse with the accept of row K-1
module conv_win_buf
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      accept,
    input  logic [K*DATA_W-1:0]       data,
    input  logic [K*DATA_W-1:0]       wt,
    input  logic                      keep_wt,
    input  logic                      is_signed,
    output logic [K*K*DATA_W-1:0]     win_d,
    output logic [K*K*DATA_W-1:0]     win_w,
    output logic                      win_signed,
    output logic                      window_full
);

    localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(K - 1);

    logic [RW-1:0]            row_q, row_d;
    logic                     keep_q, keep_d;
    logic                     sgn_q, sgn_d;
    logic [K*K*DATA_W-1:0]    win_d_q, win_d_d;
    logic [K*K*DATA_W-1:0]    win_w_q, win_w_d;
    logic                     keep_eff;

    // Row 0 must act on the incoming keep_wt, later rows on the latched copy.
    assign keep_eff = (row_q == '0) ? keep_wt : keep_q;

    always_comb begin
        row_d   = row_q;
        keep_d  = keep_q;
        sgn_d   = sgn_q;
        win_d_d = win_d_q;
        win_w_d = win_w_q;
        if (accept) begin
            row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
            if (row_q == '0) begin
                keep_d = keep_wt;
                sgn_d  = is_signed;
            end
            for (int unsigned c = 0; c < K; c++) begin
                win_d_d[(32'(row_q) * K + c) * DATA_W +: DATA_W] = data[c * DATA_W +: DATA_W];
                if (!keep_eff) begin
                    win_w_d[(32'(row_q) * K + c) * DATA_W +: DATA_W] = wt[c * DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q   <= '0;
            keep_q  <= 1'b0;
            sgn_q   <= 1'b0;
            win_d_q <= '0;
            win_w_q <= '0;
        end else begin
            row_q   <= row_d;
            keep_q  <= keep_d;
            sgn_q   <= sgn_d;
            win_d_q <= win_d_d;
            win_w_q <= win_w_d;
        end
    end

    assign win_d       = win_d_q;
    assign win_w       = win_w_q;
    assign win_signed  = sgn_q;
    assign window_full = accept && (row_q == LAST_ROW);

endmodule

// File: rtl/conv_engine.sv
// conv_engine: K x K windowed dot product with saturating output.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   data, wt       one data / weight row per accept (send && ready)
//   send, ready    row handshake; ready only while loading
//   keep_wt        sampled on row 0: reuse stored weights
//   is_signed      sampled on row 0: two's-complement operands and result
//   output_data    saturated dot product, held until the next fin
//   fin            one-cycle pulse, output_data/ovf valid
//   ovf            result was clamped
module conv_engine
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [K*DATA_W-1:0]   data,
    input  logic [K*DATA_W-1:0]   wt,
    input  logic                  send,
    output logic                  ready,
    input  logic                  keep_wt,
    input  logic                  is_signed,
    output logic [OUT_W-1:0]      output_data,
    output logic                  fin,
    output logic                  ovf
);

    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(K * K) + 1;
    localparam int unsigned P_W   = 2 * DATA_W;
    localparam int unsigned N     = K * K;

    conv_state_t state_q, state_d;

    logic                  accept;
    logic [N*DATA_W-1:0]   win_d;
    logic [N*DATA_W-1:0]   win_w;
    logic                  win_signed;
    logic                  window_full;

    logic [P_W-1:0]        prod_q [N];
    logic [P_W-1:0]        prod_d [N];
    logic signed [ACC_W-1:0] acc;
    clamp_t                cl;
    logic [OUT_W-1:0]      out_q, out_d;
    logic                  ovf_q, ovf_d;
    logic                  fin_q;
    logic                  unused_clamp_hi;

    assign ready  = (state_q == S_LOAD);
    assign accept = send && ready;

    conv_win_buf #(
        .DATA_W (DATA_W),
        .K      (K)
    ) u_win_buf (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .data        (data),
        .wt          (wt),
        .keep_wt     (keep_wt),
        .is_signed   (is_signed),
        .win_d       (win_d),
        .win_w       (win_w),
        .win_signed  (win_signed),
        .window_full (window_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  if (window_full) state_d = S_MULT;
            S_MULT:  state_d = S_SUM;
            S_SUM:   state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // One extra bit lets a single signed multiplier cover both modes: in
    // unsigned mode the extension bit is 0, and the low 2*DATA_W bits of the
    // product are exact either way.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            logic signed [DATA_W:0]    a_x;
            logic signed [DATA_W:0]    b_x;
            logic signed [2*DATA_W+1:0] full;
            a_x = {win_signed & win_d[i*DATA_W + DATA_W - 1], win_d[i*DATA_W +: DATA_W]};
            b_x = {win_signed & win_w[i*DATA_W + DATA_W - 1], win_w[i*DATA_W +: DATA_W]};
            full = a_x * b_x;
            prod_d[i] = full[P_W-1:0];
        end
    end

    // Adder tree over the registered products; ACC_W holds the worst case of
    // either mode without wrapping.
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            acc = acc + {{(ACC_W - P_W){win_signed & prod_q[i][P_W-1]}}, prod_q[i]};
        end
    end

    assign cl              = conv_clamp({{(64 - ACC_W){acc[ACC_W-1]}}, acc}, OUT_W, win_signed);
    assign unused_clamp_hi = ^cl.val[63:OUT_W];

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (state_q == S_SUM) begin
            out_d = cl.val[OUT_W-1:0];
            ovf_d = cl.ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            fin_q   <= 1'b0;
            for (int unsigned i = 0; i < N; i++) prod_q[i] <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            fin_q   <= (state_q == S_SUM);
            if (state_q == S_MULT) begin
                for (int unsigned i = 0; i < N; i++) prod_q[i] <= prod_d[i];
            end
        end
    end

    assign output_data = out_q;
    assign ovf         = ovf_q;
    assign fin         = fin_q;

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: directed windows from the test plan plus
// randomized windows, checked against an arithmetic dot-product model.
module tb_conv_engine;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned K      = 3;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned RW_W   = K * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [RW_W-1:0]   data = '0;
    logic [RW_W-1:0]   wt = '0;
    logic              send = 1'b0;
    logic              ready;
    logic              keep_wt = 1'b0;
    logic              is_signed = 1'b0;
    logic [OUT_W-1:0]  output_data;
    logic              fin;
    logic              ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // Window under test and the model's persistent weight store.
    logic [RW_W-1:0]   cur_d [K];
    logic [RW_W-1:0]   cur_w [K];
    bit                cur_keep;
    bit                cur_sgn;
    logic [DATA_W-1:0] m_w [K][K];
    longint            exp_out;
    longint            exp_ovf;

    always #5 clk = ~clk;

    conv_engine #(
        .DATA_W (DATA_W),
        .K      (K),
        .OUT_W  (OUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .wt          (wt),
        .send        (send),
        .ready       (ready),
        .keep_wt     (keep_wt),
        .is_signed   (is_signed),
        .output_data (output_data),
        .fin         (fin),
        .ovf         (ovf)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic longint elem(input logic [DATA_W-1:0] x, input bit s);
        if (s && x[DATA_W-1]) return longint'(x) - (longint'(1) << DATA_W);
        return longint'(x);
    endfunction

    task automatic model_window();
        longint sum;
        longint hi;
        longint lo;
        if (!cur_keep) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    m_w[r][c] = cur_w[r][c*DATA_W +: DATA_W];
        end
        sum = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                sum += elem(cur_d[r][c*DATA_W +: DATA_W], cur_sgn) * elem(m_w[r][c], cur_sgn);
        if (cur_sgn) begin
            hi = (longint'(1) << (OUT_W - 1)) - 1;
            lo = -(longint'(1) << (OUT_W - 1));
        end else begin
            hi = (longint'(1) << OUT_W) - 1;
            lo = 0;
        end
        exp_ovf = (sum > hi || sum < lo) ? 1 : 0;
        if (sum > hi) sum = hi;
        if (sum < lo) sum = lo;
        exp_out = sum & ((longint'(1) << OUT_W) - 1);
    endtask

    task automatic model_reset();
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                m_w[r][c] = '0;
    endtask

    // Presents row r at a negedge, waits for ready, returns at the negedge
    // after the accepting edge.
    task automatic drive_row(input int r, input bit gaps);
        int g;
        int n;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < g; i++) begin
            send = 1'b0;
            data = RW_W'($urandom);
            wt   = RW_W'($urandom);
            @(negedge clk);
        end
        send      = 1'b1;
        data      = cur_d[r];
        wt        = cur_w[r];
        keep_wt   = (r == 0) ? cur_keep : 1'($urandom);
        is_signed = (r == 0) ? cur_sgn  : 1'($urandom);
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_eq("ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_window(input string tag, input bit gaps, input bit hold);
        int lat;
        model_window();
        for (int r = 0; r < K; r++) drive_row(r, gaps);
        // Now one negedge past the last accept.
        if (hold) begin
            send = 1'b1;
            data = RW_W'($urandom);
            wt   = RW_W'($urandom);
        end else begin
            send = 1'b0;
        end
        lat = 1;
        while (!fin && lat < 10) begin
            if (hold) check_eq({tag, "_busy_ready"}, longint'(ready), 0);
            @(negedge clk);
            lat++;
        end
        send = 1'b0;
        check_eq({tag, "_fin"}, longint'(fin), 1);
        check_eq({tag, "_latency"}, longint'(lat), 3);
        check_eq({tag, "_data"}, longint'(output_data), exp_out);
        check_eq({tag, "_ovf"}, longint'(ovf), exp_ovf);
        check_eq({tag, "_ready_at_fin"}, longint'(ready), 1);
        @(negedge clk);
        check_eq({tag, "_fin_pulse"}, longint'(fin), 0);
        check_eq({tag, "_data_hold"}, longint'(output_data), exp_out);
    endtask

    task automatic set_uniform(input logic [RW_W-1:0] d, input logic [RW_W-1:0] w,
                               input bit keep, input bit sgn);
        for (int r = 0; r < K; r++) begin
            cur_d[r] = d;
            cur_w[r] = w;
        end
        cur_keep = keep;
        cur_sgn  = sgn;
    endtask

    initial begin
        model_reset();
        // Reset state, with send asserted to show it is ignored.
        send = 1'b1;
        data = 24'h111111;
        wt   = 24'h111111;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", longint'(ready), 1);
        check_eq("rst_fin", longint'(fin), 0);
        check_eq("rst_data", longint'(output_data), 0);
        check_eq("rst_ovf", longint'(ovf), 0);
        send = 1'b0;
        rst  = 1'b1;
        @(negedge clk);

        // keep_wt straight after reset uses the cleared weights.
        set_uniform(24'h050505, 24'hFFFFFF, 1'b1, 1'b0);
        run_window("zero_wt", 1'b0, 1'b0);
        check_eq("zero_wt_const", longint'(output_data), 0);

        set_uniform(24'h010101, 24'h020202, 1'b0, 1'b0);
        run_window("basic", 1'b0, 1'b0);
        check_eq("basic_const", longint'(output_data), 18);

        set_uniform(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        run_window("usat", 1'b0, 1'b0);
        check_eq("usat_const", longint'(output_data), 16'hFFFF);

        set_uniform(24'hFFFFFF, 24'h030303, 1'b0, 1'b1);
        run_window("sneg", 1'b0, 1'b0);
        check_eq("sneg_const", longint'(output_data), 16'hFFE5);

        set_uniform(24'h808080, 24'h7F7F7F, 1'b0, 1'b1);
        run_window("ssat", 1'b0, 1'b0);
        check_eq("ssat_const", longint'(output_data), 16'h8000);

        set_uniform(24'h010101, 24'h020202, 1'b0, 1'b0);
        run_window("reuse1", 1'b0, 1'b0);
        set_uniform(24'h030303, 24'hFFFFFF, 1'b1, 1'b0);
        run_window("reuse2", 1'b0, 1'b0);
        check_eq("reuse2_const", longint'(output_data), 54);

        set_uniform(24'h010101, 24'h020202, 1'b0, 1'b0);
        run_window("gaps", 1'b1, 1'b0);
        run_window("hold", 1'b0, 1'b1);

        // Reset after two rows: partial window discarded, outputs cleared.
        set_uniform(24'h0A0B0C, 24'h010203, 1'b0, 1'b0);
        drive_row(0, 1'b0);
        drive_row(1, 1'b0);
        rst  = 1'b0;
        send = 1'b1;
        model_reset();
        #1;
        check_eq("midrst_data", longint'(output_data), 0);
        check_eq("midrst_ovf", longint'(ovf), 0);
        check_eq("midrst_ready", longint'(ready), 1);
        repeat (2) @(negedge clk);
        send = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("midrst_no_fin", longint'(fin), 0);
        end
        set_uniform(24'h010101, 24'h020202, 1'b0, 1'b0);
        run_window("post_rst", 1'b0, 1'b0);
        check_eq("post_rst_const", longint'(output_data), 18);

        // Randomized windows: operands, mode, weight reuse, gaps, held send.
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < K; r++) begin
                cur_d[r] = RW_W'($urandom);
                cur_w[r] = RW_W'($urandom);
            end
            cur_keep = ($urandom_range(0, 3) == 0);
            cur_sgn  = 1'($urandom);
            run_window($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
